pipeline_seq_ctrl: RTL and testbench

Central sequencer for the 5-stage RISC-V pipeline's register enables and flushes.
- Merges load-use stall requests from the hazard detector, EX-stage branch redirects, instruction/data memory wait states, and a multi-cycle MUL/DIV unit handshake.
- Drives per-stage enable/flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Owns the FSM that parks the pipeline while a MUL/DIV operation is in EX.

---
 rtl/pipeline_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipeline_seq_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_seq_ctrl.sv
// Pipeline enable/flush sequencer for the 5-stage core, including the MUL/DIV park FSM.
// Optional performance counters are compiled in when PERF_CNT_EN is defined.
module pipeline_seq_ctrl #(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_use_stall,
   input  logic             branch_taken,
   input  logic             ex_is_md,
   input  logic             md_done,
   input  logic             imem_ready,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             ex_mem_flush,
   output logic             mem_wb_en,
   output logic             md_start,
   output logic             md_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // state   | meaning
   // ST_RUN  | normal issue; strobes follow hazard/redirect priority
   // ST_MD   | MUL/DIV op parked in EX, front end frozen until done/timeout
   typedef enum logic {
      ST_RUN = 1'b0,
      ST_MD  = 1'b1
   } state_e;

   localparam int                  MD_CNT_W = $clog2(MD_TIMEOUT);
   localparam logic [MD_CNT_W-1:0] MD_LAST  = MD_CNT_W'(MD_TIMEOUT - 1);
   localparam logic [MD_CNT_W-1:0] MD_ONE   = MD_CNT_W'(1);

   state_e              state_q, state_d;
   logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic                md_done_q, md_done_d;
   logic                md_timeout_q, md_timeout_d;
   logic                mem_stall;
   logic                redirect;

   assign mem_stall  = mem_access & ~dmem_ready;
   assign md_timeout = md_timeout_q;

   always_comb begin
      state_d      = state_q;
      md_cnt_d     = md_cnt_q;
      md_done_d    = md_done_q;
      md_timeout_d = md_timeout_q;
      redirect     = 1'b0;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_en    = 1'b0;
      md_start     = 1'b0;

      if (mem_stall) begin
         // Whole pipe frozen; a completion arriving now must not be lost.
         if ((state_q == ST_MD) && md_done) begin
            md_done_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (ex_is_md) begin
                  md_start     = 1'b1;
                  ex_mem_flush = 1'b1;
                  mem_wb_en    = 1'b1;
                  md_cnt_d     = '0;
                  state_d      = ST_MD;
               end else if (branch_taken) begin
                  redirect     = 1'b1;
                  pc_en        = 1'b1;
                  if_id_flush  = 1'b1;
                  id_ex_flush  = 1'b1;
                  ex_mem_en    = 1'b1;
                  mem_wb_en    = 1'b1;
               end else if (load_use_stall) begin
                  id_ex_flush  = 1'b1;
                  ex_mem_en    = 1'b1;
                  mem_wb_en    = 1'b1;
               end else if (!imem_ready) begin
                  if_id_flush  = 1'b1;
                  id_ex_en     = 1'b1;
                  ex_mem_en    = 1'b1;
                  mem_wb_en    = 1'b1;
               end else begin
                  pc_en        = 1'b1;
                  if_id_en     = 1'b1;
                  id_ex_en     = 1'b1;
                  ex_mem_en    = 1'b1;
                  mem_wb_en    = 1'b1;
               end
            end
            ST_MD: begin
               ex_mem_flush = 1'b1;
               mem_wb_en    = 1'b1;
               md_cnt_d     = md_cnt_q + MD_ONE;
               if (md_done || md_done_q) begin
                  ex_mem_en    = 1'b1;
                  ex_mem_flush = 1'b0;
                  md_done_d    = 1'b0;
                  state_d      = ST_RUN;
               end else if (md_cnt_q == MD_LAST) begin
                  md_timeout_d = 1'b1;
                  state_d      = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end

      // Strobes are combinational, so reset must mask them directly.
      if (rst) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_en     = 1'b0;
         id_ex_flush  = 1'b0;
         ex_mem_en    = 1'b0;
         ex_mem_flush = 1'b0;
         mem_wb_en    = 1'b0;
         md_start     = 1'b0;
         redirect     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_RUN;
         md_cnt_q     <= '0;
         md_done_q    <= 1'b0;
         md_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         md_cnt_q     <= md_cnt_d;
         md_done_q    <= md_done_d;
         md_timeout_q <= md_timeout_d;
      end
   end

`ifdef PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (!pc_en) begin
         stall_count_d = stall_count_q + CNT_ONE;
      end
      if (redirect) begin
         flush_count_d = flush_count_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// Directed scoreboard bench for pipeline_seq_ctrl (MD_TIMEOUT=8).
module tb_pipeline_seq_ctrl;

   localparam int CNT_W = 16;

   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en, md_start, md_timeout}
   localparam logic [9:0] RUN_ALL = 10'b1101010100;
   localparam logic [9:0] LU      = 10'b0000110100;
   localparam logic [9:0] BR      = 10'b1010110100;
   localparam logic [9:0] IMW     = 10'b0011010100;
   localparam logic [9:0] MDS     = 10'b0000001110;
   localparam logic [9:0] BUSY    = 10'b0000001100;
   localparam logic [9:0] DONE    = 10'b0000010100;
   localparam logic [9:0] ZERO    = 10'b0000000000;
   localparam logic [9:0] TO      = 10'b0000000001;

   logic clk;
   logic rst;
   logic load_use_stall, branch_taken, ex_is_md, md_done;
   logic imem_ready, mem_access, dmem_ready;
   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
   logic ex_mem_en, ex_mem_flush, mem_wb_en, md_start, md_timeout;
   logic [CNT_W-1:0] stall_count, flush_count;

   int n_cmp = 0;
   int n_mis = 0;
   int exp_stall = 0;
   int exp_flush = 0;
   logic [9:0] exp_q[$];
   string      tag_q[$];

   pipeline_seq_ctrl #(.MD_TIMEOUT(8), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .load_use_stall (load_use_stall),
      .branch_taken   (branch_taken),
      .ex_is_md       (ex_is_md),
      .md_done        (md_done),
      .imem_ready     (imem_ready),
      .mem_access     (mem_access),
      .dmem_ready     (dmem_ready),
      .pc_en          (pc_en),
      .if_id_en       (if_id_en),
      .if_id_flush    (if_id_flush),
      .id_ex_en       (id_ex_en),
      .id_ex_flush    (id_ex_flush),
      .ex_mem_en      (ex_mem_en),
      .ex_mem_flush   (ex_mem_flush),
      .mem_wb_en      (mem_wb_en),
      .md_start       (md_start),
      .md_timeout     (md_timeout),
      .stall_count    (stall_count),
      .flush_count    (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, queue the expectation, check at the falling edge.
   task automatic step(input logic r, input logic lu, input logic br, input logic md,
                       input logic dn, input logic im, input logic ma, input logic dr,
                       input logic [9:0] e, input string t);
      logic [9:0] obs;
      logic [9:0] ex;
      string      tg;
      logic [CNT_W-1:0] es;
      logic [CNT_W-1:0] ef;
      rst = r; load_use_stall = lu; branch_taken = br; ex_is_md = md;
      md_done = dn; imem_ready = im; mem_access = ma; dmem_ready = dr;
      exp_q.push_back(e);
      tag_q.push_back(t);
      @(negedge clk);
      ex  = exp_q.pop_front();
      tg  = tag_q.pop_front();
      obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_en, ex_mem_flush, mem_wb_en, md_start, md_timeout};
      n_cmp++;
      assert (obs === ex) else begin
         n_mis++;
         $error("FAIL %s strobes: observed %b expected %b", tg, obs, ex);
      end
`ifdef PERF_CNT_EN
      es = CNT_W'(exp_stall);
      ef = CNT_W'(exp_flush);
`else
      es = '0;
      ef = '0;
`endif
      n_cmp++;
      assert (stall_count === es) else begin
         n_mis++;
         $error("FAIL %s stall_count: observed %0d expected %0d", tg, stall_count, es);
      end
      n_cmp++;
      assert (flush_count === ef) else begin
         n_mis++;
         $error("FAIL %s flush_count: observed %0d expected %0d", tg, flush_count, ef);
      end
      if (r) begin
         exp_stall = 0;
         exp_flush = 0;
      end else begin
         if (!ex[9]) exp_stall++;
         if ((ex & ~TO) == BR) exp_flush++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; load_use_stall = 1'b0; branch_taken = 1'b0; ex_is_md = 1'b0;
      md_done = 1'b0; imem_ready = 1'b1; mem_access = 1'b0; dmem_ready = 1'b1;

      //    r  lu br md dn im ma dr
      step(1, 0, 0, 0, 0, 1, 0, 1, ZERO,    "reset0");
      step(1, 0, 1, 1, 0, 1, 0, 1, ZERO,    "reset1");
      step(0, 0, 0, 0, 0, 1, 0, 1, RUN_ALL, "idle0");

      step(0, 1, 0, 0, 0, 1, 0, 1, LU,      "loaduse");
      step(0, 0, 0, 0, 0, 1, 0, 1, RUN_ALL, "after_lu");
      step(0, 1, 1, 0, 0, 1, 0, 1, BR,      "br_over_lu");
      step(0, 0, 1, 0, 0, 0, 0, 1, BR,      "br_over_imw");
      step(0, 0, 0, 0, 0, 0, 0, 1, IMW,     "imem_wait");
      step(0, 0, 0, 0, 0, 1, 0, 1, RUN_ALL, "idle1");

      step(0, 0, 0, 1, 0, 1, 0, 1, MDS,     "md_start");
      step(0, 0, 0, 0, 0, 1, 0, 1, BUSY,    "md_busy1");
      step(0, 0, 0, 0, 0, 1, 0, 1, BUSY,    "md_busy2");
      step(0, 0, 0, 0, 0, 1, 0, 1, BUSY,    "md_busy3");
      step(0, 0, 0, 0, 0, 1, 0, 1, BUSY,    "md_busy4");
      step(0, 0, 0, 0, 1, 1, 0, 1, DONE,    "md_done5");
      step(0, 0, 0, 0, 0, 1, 0, 1, RUN_ALL, "md_back_run");

      step(0, 0, 0, 1, 1, 1, 0, 1, MDS,     "md_done_in_start");
      step(0, 0, 0, 0, 0, 1, 0, 1, BUSY,    "md_still_busy");
      step(0, 0, 0, 0, 1, 1, 0, 1, DONE,    "md_done_late");

      step(0, 0, 1, 1, 0, 1, 0, 1, MDS,     "md_over_branch");
      step(0, 0, 0, 0, 0, 1, 0, 1, BUSY,    "md_busy_b");
      step(0, 0, 0, 0, 0, 1, 1, 0, ZERO,    "md_memstall1");
      step(0, 0, 0, 0, 1, 1, 1, 0, ZERO,    "md_memstall2");
      step(0, 0, 0, 0, 0, 1, 1, 0, ZERO,    "md_memstall3");
      step(0, 0, 0, 0, 0, 1, 0, 1, DONE,    "md_done_q");
      step(0, 0, 0, 0, 0, 1, 0, 1, RUN_ALL, "after_done_q");

      step(0, 0, 1, 0, 0, 1, 1, 0, ZERO,    "run_memstall");
      step(0, 0, 0, 0, 0, 1, 1, 1, RUN_ALL, "mem_ready");

      step(0, 0, 0, 1, 0, 1, 0, 1, MDS,     "rst_md_start");
      step(0, 0, 0, 1, 0, 1, 0, 1, BUSY,    "rst_md_busy");
      step(1, 0, 0, 1, 0, 1, 0, 1, ZERO,    "rst_mid_md0");
      step(1, 0, 0, 1, 0, 1, 0, 1, ZERO,    "rst_mid_md1");
      step(0, 0, 0, 1, 0, 1, 0, 1, MDS,     "rst_release_run");
      step(0, 0, 0, 0, 1, 1, 0, 1, DONE,    "rst_md_done");

      step(0, 0, 0, 1, 0, 1, 0, 1, MDS,     "to_start");
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 0, 0, 1, 0, 1, BUSY, $sformatf("to_busy%0d", i));
      end
      step(0, 0, 0, 0, 0, 1, 0, 1, RUN_ALL | TO, "to_run");
      step(0, 1, 0, 0, 0, 1, 0, 1, LU | TO,      "to_sticky_lu");
      step(0, 0, 0, 0, 0, 1, 1, 0, ZERO | TO,    "to_sticky_stall");
      step(1, 0, 0, 0, 0, 1, 0, 1, ZERO,         "to_cleared");
      step(0, 0, 0, 0, 0, 1, 0, 1, RUN_ALL,      "final_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
